// File: rtl/ray_pkg.sv
// -----------------------------------------------------------------------------
// ray_pkg
// Shared definitions for the ray pipeline sink blocks.
//   COLOR_W           : default pixel colour width (RGB888)
//   IDX_W             : default pixel index width carried with each result
//   DIM_W             : frame dimension width (width / height / column / row)
//   collector_state_t : sequencing states of the pixel result collector
//   pixel_t           : one shaded result, colour plus the index it belongs to
// -----------------------------------------------------------------------------
package ray_pkg;

    localparam int COLOR_W = 24;
    localparam int IDX_W   = 32;
    localparam int DIM_W   = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } collector_state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [IDX_W-1:0]   index;
    } pixel_t;

endpackage

// File: rtl/result_hold_slot.sv
// -----------------------------------------------------------------------------
// result_hold_slot
// One-entry valid/ready holding register for a single tracer core.
// The entry is filled by an in_valid/in_ready handshake and freed by consume.
// in_ready only depends on registered state, so a consumed entry reopens one
// cycle later and the core sustains at most one result every two cycles.
//   clk, reset_n : clock, synchronous active-low reset
//   enable       : slot may accept results (collector running, core active)
//   flush        : drop any held entry (new frame)
//   in_valid     : core result valid
//   in_ready     : slot can accept a result this cycle
//   in_data      : core result payload
//   consume      : collector takes the held entry this cycle
//   hold_valid   : entry occupied
//   hold_data    : held payload
// -----------------------------------------------------------------------------
module result_hold_slot
    import ray_pkg::*;
#(
    parameter type data_t = pixel_t
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  enable,
    input  logic  flush,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_data,
    input  logic  consume,
    output logic  hold_valid,
    output data_t hold_data
);

    logic fill;

    assign in_ready = enable && !hold_valid;
    assign fill     = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the order of statements cannot matter.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            hold_valid <= 1'b0;
        end else if (consume) begin
            hold_valid <= 1'b0;
        end else if (fill) begin
            hold_valid <= 1'b1;
        end
    end

    // NOTE: the payload register has no reset; it is only observed while
    // hold_valid is set, so resetting it would just add reset fan-out.
    always_ff @(posedge clk) begin
        if (fill) begin
            hold_data <= in_data;
        end
    end

endmodule

// File: rtl/pixel_result_collector.sv
// -----------------------------------------------------------------------------
// pixel_result_collector
// Sink end of the ray pipeline. Tracer cores interleave pixel indices (core c
// owns c, c+N, c+2N, ...). Results are parked in one hold slot per core and
// re-serialised into raster order on a single valid/ready pixel stream with
// start-of-frame (out_user) and end-of-line (out_last) markers. The carried
// index of every result is compared with the expected raster index; any
// mismatch, or any result offered by an inactive core, sets seq_error.
//   clk, reset_n             : clock, synchronous active-low reset
//   start                    : frame start pulse, honoured only in IDLE
//   image_width/height       : frame dimensions, latched on start
//   op_code                  : active cores minus one, latched on start
//   res_valid/ready          : per-core result handshake
//   res_color/res_index      : packed per-core payloads, core c at slice c
//   out_valid/ready          : output pixel handshake
//   out_data                 : output colour
//   out_user                 : first pixel of the frame
//   out_last                 : last pixel of a line
//   busy                     : frame in progress (RUN or DRAIN)
//   frame_done               : one-cycle pulse after the final pixel leaves
//   seq_error                : sticky index/protocol error, cleared on start
// -----------------------------------------------------------------------------
module pixel_result_collector
    import ray_pkg::DIM_W, ray_pkg::collector_state_t, ray_pkg::IDLE, ray_pkg::RUN, ray_pkg::DRAIN;
#(
    parameter int MAX_CORES = 4,
    parameter int COLOR_W   = ray_pkg::COLOR_W,
    parameter int IDX_W     = ray_pkg::IDX_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [DIM_W-1:0]             image_width,
    input  logic [DIM_W-1:0]             image_height,
    input  logic [1:0]                   op_code,
    input  logic [MAX_CORES-1:0]         res_valid,
    output logic [MAX_CORES-1:0]         res_ready,
    input  logic [MAX_CORES*COLOR_W-1:0] res_color,
    input  logic [MAX_CORES*IDX_W-1:0]   res_index,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLOR_W-1:0]           out_data,
    output logic                         out_user,
    output logic                         out_last,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         seq_error
);

    localparam int SEL_W = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;

    // Same layout as ray_pkg::pixel_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [IDX_W-1:0]   index;
    } result_t;

    collector_state_t state, next_state;

    logic [DIM_W-1:0]     width_q;
    logic [DIM_W-1:0]     height_q;
    logic [DIM_W-1:0]     col;
    logic [DIM_W-1:0]     row;
    logic [1:0]           last_core;     // N-1 of the running frame
    logic [MAX_CORES-1:0] active_mask;   // bit c set when core c < N
    logic [SEL_W-1:0]     core_sel;      // exp_idx mod N, kept as a wrapping count
    logic [IDX_W-1:0]     exp_idx;

    logic [MAX_CORES-1:0] hold_valid;
    logic [MAX_CORES-1:0] slot_ready;
    logic [MAX_CORES-1:0] consume;
    result_t              slot_in   [MAX_CORES];
    result_t              hold_data [MAX_CORES];

    logic    running;
    logic    dims_ok;
    logic    start_frame;
    logic    sel_valid;
    result_t sel_data;
    logic    load;
    logic    out_fire;
    logic    line_end;
    logic    frame_end;
    logic    drop_inactive;

    assign running     = (state == RUN);
    assign busy        = (state != IDLE);
    assign dims_ok     = (image_width != '0) && (image_height != '0);
    assign start_frame = (state == IDLE) && start && dims_ok;

    // ------------------------------------------------------------------
    // Per-core hold slots. Inactive cores bypass their slot: they are kept
    // ready while running so a misbehaving core cannot stall the frame, and
    // whatever they offer is discarded and flagged.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < MAX_CORES; c++) begin : g_slot
        assign slot_in[c] = {res_color[c*COLOR_W +: COLOR_W], res_index[c*IDX_W +: IDX_W]};

        result_hold_slot #(
            .data_t (result_t)
        ) u_slot (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (running && active_mask[c]),
            .flush      (start_frame),
            .in_valid   (res_valid[c]),
            .in_ready   (slot_ready[c]),
            .in_data    (slot_in[c]),
            .consume    (consume[c]),
            .hold_valid (hold_valid[c]),
            .hold_data  (hold_data[c])
        );

        assign res_ready[c] = running && (active_mask[c] ? slot_ready[c] : 1'b1);
    end

    assign drop_inactive = running && ((res_valid & ~active_mask) != '0);

    // ------------------------------------------------------------------
    // Raster sequencing: only the slot owning the next raster index may
    // feed the output register, so arrival order across cores is irrelevant.
    // ------------------------------------------------------------------
    assign sel_valid = hold_valid[core_sel];
    assign sel_data  = hold_data[core_sel];
    assign load      = running && sel_valid && (!out_valid || out_ready);
    assign out_fire  = out_valid && out_ready;
    assign line_end  = (col == width_q - DIM_W'(1));
    assign frame_end = line_end && (row == height_q - DIM_W'(1));

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        consume = '0;
        if (load) begin
            consume[core_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_frame)        next_state = RUN;
            RUN:     if (load && frame_end)  next_state = DRAIN;
            DRAIN:   if (out_fire)           next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parameters, raster counters, output register and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            width_q     <= '0;
            height_q    <= '0;
            last_core   <= '0;
            active_mask <= '0;
            exp_idx     <= '0;
            col         <= '0;
            row         <= '0;
            core_sel    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_user    <= 1'b0;
            out_last    <= 1'b0;
            frame_done  <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (state == IDLE && start) begin
                seq_error <= 1'b0;
                if (dims_ok) begin
                    width_q   <= image_width;
                    height_q  <= image_height;
                    last_core <= op_code;
                    for (int c = 0; c < MAX_CORES; c++) begin
                        active_mask[c] <= (c <= int'(op_code));
                    end
                    exp_idx  <= '0;
                    col      <= '0;
                    row      <= '0;
                    core_sel <= '0;
                end else begin
                    // Empty frame: nothing to stream, report completion at once.
                    frame_done <= 1'b1;
                end
            end

            if (state == DRAIN && out_fire) begin
                frame_done <= 1'b1;
            end

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= sel_data.color;
                out_user  <= (exp_idx == '0);
                out_last  <= line_end;
                exp_idx   <= exp_idx + IDX_W'(1);
                if (line_end) begin
                    col <= '0;
                    row <= row + DIM_W'(1);
                end else begin
                    col <= col + DIM_W'(1);
                end
                if (int'(core_sel) == int'(last_core)) begin
                    core_sel <= '0;
                end else begin
                    core_sel <= core_sel + SEL_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A mismatched result is still forwarded; only the flag records it.
            if ((load && (sel_data.index != exp_idx)) || drop_inactive) begin
                seq_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_result_collector.sv
// -----------------------------------------------------------------------------
// tb_pixel_result_collector
// Drives frames into pixel_result_collector from per-core producers and checks
// the output stream against the raster-order expectation: pixel k carries the
// colour generated for index k, out_user on k==0, out_last when k mod width is
// width-1, frame_done once after the final pixel, seq_error from injected
// index faults. Directed frames come from a vector table; random frames follow.
// -----------------------------------------------------------------------------
module tb_pixel_result_collector;

    localparam int MAXC = 4;
    localparam int CW   = 24;
    localparam int IW   = 32;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [12:0]          image_width;
    logic [12:0]          image_height;
    logic [1:0]           op_code;
    logic [MAXC-1:0]      res_valid;
    logic [MAXC-1:0]      res_ready;
    logic [MAXC*CW-1:0]   res_color;
    logic [MAXC*IW-1:0]   res_index;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        out_data;
    logic                 out_user;
    logic                 out_last;
    logic                 busy;
    logic                 frame_done;
    logic                 seq_error;

    int n_tests = 0;
    int n_fail  = 0;

    pixel_result_collector #(
        .MAX_CORES (MAXC),
        .COLOR_W   (CW),
        .IDX_W     (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .image_width  (image_width),
        .image_height (image_height),
        .op_code      (op_code),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_color    (res_color),
        .res_index    (res_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_user     (out_user),
        .out_last     (out_last),
        .busy         (busy),
        .frame_done   (frame_done),
        .seq_error    (seq_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gate : 0 = producers always offer, 1 = fixed staggered start per core,
    //        2 = random offers.   bp : 0 = always ready, 1 = toggling, 2 = random.
    task automatic run_frame(input string tag, input int w, input int h, input int op,
                             input int gate, input int bp, input int bad_pos,
                             input int abort_after, input bit poke_start,
                             output int pixels, output logic err_end);
        int            n;
        int            total;
        int            acc;
        int            cyc;
        int            early_fd;
        int            sent  [MAXC];
        bit            pend  [MAXC];
        int            delay [MAXC];
        logic [CW-1:0] colors [];
        logic [MAXC-1:0] fire_in;
        bit            fire_out;
        bit            stall;
        logic [CW+1:0] held;

        n        = op + 1;
        total    = w * h;
        acc      = 0;
        cyc      = 0;
        early_fd = 0;
        stall    = 1'b0;
        held     = '0;
        delay    = '{6, 3, 9, 0};   // core 3 first, then 1, 0, 2
        colors   = new[total];
        foreach (colors[i]) colors[i] = CW'($urandom);
        for (int c = 0; c < MAXC; c++) begin
            sent[c] = 0;
            pend[c] = 1'b0;
        end

        image_width  = 13'(w);
        image_height = 13'(h);
        op_code      = 2'(op);
        start        = 1'b1;
        step();
        start = 1'b0;
        check({tag, " busy after start"}, busy, 1);

        while (acc < total && cyc < 4000) begin
            for (int c = 0; c < MAXC; c++) begin
                int  idx;
                bit  want;
                idx  = c + n * sent[c];
                want = (c < n) && (idx < total) &&
                       (pend[c] || gate == 0 || (gate == 1 && cyc >= delay[c]) ||
                        (gate == 2 && $urandom_range(0, 1) == 1));
                res_valid[c] = want;
                pend[c]      = want;
                if (want) begin
                    res_color[c*CW +: CW] = colors[idx];
                    res_index[c*IW +: IW] = IW'((idx == bad_pos) ? idx + 4 : idx);
                end
            end
            case (bp)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (poke_start) begin
                start        = ($urandom_range(0, 7) == 0);
                image_width  = 13'($urandom);
                image_height = 13'($urandom);
                op_code      = 2'($urandom);
            end
            #1;
            fire_in  = res_valid & res_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                check($sformatf("%s px%0d data", tag, acc), out_data, colors[acc]);
                check($sformatf("%s px%0d user", tag, acc), out_user, (acc == 0));
                check($sformatf("%s px%0d last", tag, acc), out_last, (acc % w == w - 1));
                check($sformatf("%s px%0d seq_error", tag, acc), seq_error,
                      (bad_pos >= 0 && acc >= bad_pos));
            end
            stall = out_valid && !out_ready;
            if (stall) held = {out_user, out_last, out_data};
            if (frame_done) early_fd++;
            step();
            for (int c = 0; c < MAXC; c++) begin
                if (fire_in[c]) begin
                    sent[c]++;
                    pend[c] = 1'b0;
                end
            end
            if (fire_out) acc++;
            if (stall) begin
                check($sformatf("%s hold px%0d", tag, acc), {out_valid, out_user, out_last, out_data},
                      {1'b1, held});
            end
            cyc++;
            if (abort_after >= 0 && acc == abort_after) begin
                start     = 1'b0;
                res_valid = '0;
                pixels    = acc;
                err_end   = seq_error;
                return;
            end
        end

        start     = 1'b0;
        res_valid = '0;
        out_ready = 1'b1;
        check({tag, " no early frame_done"}, early_fd, 0);
        check({tag, " frame_done pulse"}, frame_done, 1);
        check({tag, " idle after frame"}, busy, 0);
        pixels  = acc;
        err_end = seq_error;
        step();
        check({tag, " frame_done single"}, frame_done, 0);
    endtask

    typedef struct {
        int   w;
        int   h;
        int   op;
        int   gate;
        int   bp;
        int   bad_pos;
        int   exp_pixels;
        logic exp_err;
    } frame_vec_t;

    initial begin
        frame_vec_t vecs [6];
        int         pixels;
        logic       err_end;
        int         zero_ov;

        vecs[0] = '{w: 2, h: 2, op: 0, gate: 0, bp: 0, bad_pos: -1, exp_pixels: 4,  exp_err: 1'b0};
        vecs[1] = '{w: 4, h: 2, op: 3, gate: 1, bp: 0, bad_pos: -1, exp_pixels: 8,  exp_err: 1'b0};
        vecs[2] = '{w: 3, h: 1, op: 1, gate: 0, bp: 1, bad_pos: -1, exp_pixels: 3,  exp_err: 1'b0};
        vecs[3] = '{w: 1, h: 2, op: 0, gate: 0, bp: 0, bad_pos: 1,  exp_pixels: 2,  exp_err: 1'b1};
        vecs[4] = '{w: 5, h: 3, op: 1, gate: 2, bp: 2, bad_pos: -1, exp_pixels: 15, exp_err: 1'b0};
        vecs[5] = '{w: 1, h: 1, op: 3, gate: 2, bp: 1, bad_pos: -1, exp_pixels: 1,  exp_err: 1'b0};

        reset_n      = 1'b0;
        start        = 1'b0;
        image_width  = '0;
        image_height = '0;
        op_code      = '0;
        res_valid    = '0;
        res_color    = '0;
        res_index    = '0;
        out_ready    = 1'b1;
        step();
        step();
        check("reset out_valid", out_valid, 0);
        check("reset outputs", {out_data, out_user, out_last}, 0);
        check("reset status", {busy, frame_done, seq_error}, 0);
        check("reset res_ready", res_ready, 0);
        reset_n = 1'b1;

        // Results offered before any start must not be taken.
        res_valid = '1;
        step();
        check("idle res_ready", res_ready, 0);
        step();
        check("idle no output", {out_valid, busy}, 0);
        res_valid = '0;

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].w, vecs[i].h, vecs[i].op, vecs[i].gate,
                      vecs[i].bp, vecs[i].bad_pos, -1, 1'b0, pixels, err_end);
            check($sformatf("vec%0d pixel count", i), pixels, vecs[i].exp_pixels);
            check($sformatf("vec%0d seq_error", i), err_end, vecs[i].exp_err);
        end

        // Zero dimension: completion pulse only, no stream.
        image_width  = 13'd0;
        image_height = 13'd5;
        op_code      = 2'd0;
        start        = 1'b1;
        step();
        start = 1'b0;
        check("zero-dim frame_done", frame_done, 1);
        check("zero-dim busy", busy, 0);
        zero_ov = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid || busy || frame_done) zero_ov++;
        end
        check("zero-dim quiet", zero_ov, 0);

        // Inactive core: accepted while running, dropped, and flagged.
        image_width  = 13'd2;
        image_height = 13'd1;
        op_code      = 2'd1;
        start        = 1'b1;
        step();
        start     = 1'b0;
        res_valid = 4'b1000;
        #1;
        check("inactive ready", res_ready[3:2], 2'b11);
        step();
        res_valid = '0;
        check("inactive seq_error", seq_error, 1);
        check("inactive no output", out_valid, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;

        // Random frames with random backpressure and ignored mid-frame starts.
        for (int i = 0; i < 6; i++) begin
            int w;
            int h;
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            run_frame($sformatf("rnd%0d", i), w, h, $urandom_range(0, 3), 2, 2, -1, -1, 1'b1,
                      pixels, err_end);
            check($sformatf("rnd%0d pixel count", i), pixels, w * h);
            check($sformatf("rnd%0d seq_error", i), err_end, 0);
        end

        // Reset in the middle of an 8x8 frame, then a clean 2x2 frame.
        run_frame("abort", 8, 8, 0, 0, 0, -1, 10, 1'b0, pixels, err_end);
        check("abort reached", pixels, 10);
        reset_n = 1'b0;
        step();
        check("abort out_valid", out_valid, 0);
        check("abort outputs", {out_data, out_user, out_last}, 0);
        check("abort status", {busy, frame_done, seq_error}, 0);
        check("abort res_ready", res_ready, 0);
        reset_n = 1'b1;
        step();
        check("abort no frame_done", frame_done, 0);
        run_frame("post", 2, 2, 0, 0, 0, -1, -1, 1'b0, pixels, err_end);
        check("post pixel count", pixels, 4);
        check("post seq_error", err_end, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
